// File: rtl/keypad_entry_collector.sv
// keypad_entry_collector
//   Scans a 4x4 active-low matrix keypad, debounces press and release, decodes
//   the key and accumulates digits into a nibble buffer (nibble 0 = newest).
//   Enter (*), abort (#) and an idle timeout each emit a one-cycle frame strobe.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable         scanning allowed when high
//   col_matriz     column sense, active-low (bit 3-c low = column c)
//   lin_matriz     row drive, active-low one-hot (bit 3-r low = row r)
//   digits_value   digit buffer, unused nibbles read 0xF
//   digits_valid   one-cycle frame strobe
//   digit_count    number of digits held
//   frame_kind     0 = enter, 1 = abort, 2 = timeout (valid with digits_valid)
module keypad_entry_collector #(
  parameter int unsigned DIGITS         = 20,
  parameter int unsigned DB_CYCLES      = 100,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [3:0]                  col_matriz,
  output logic [3:0]                  lin_matriz,
  output logic [4*DIGITS-1:0]         digits_value,
  output logic                        digits_valid,
  output logic [$clog2(DIGITS+1)-1:0] digit_count,
  output logic [1:0]                  frame_kind
);

  localparam int unsigned ValW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ValW-1:0] AllF = {DIGITS{4'hF}};
  localparam logic [ValW-1:0] AllB = {DIGITS{4'hB}};
  localparam logic [ValW-1:0] AllE = {DIGITS{4'hE}};
  localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] KindEnter   = 2'd0;
  localparam logic [1:0] KindAbort   = 2'd1;
  localparam logic [1:0] KindTimeout = 2'd2;

  typedef enum logic [2:0] {
    StScan, StDebounce, StDecode, StWaitRelease, StDisabled
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [DbW-1:0]  db_q, db_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [ValW-1:0] val_q, val_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [1:0]      kind_q, kind_d;

  logic [3:0]      col_low;
  logic            single_low;
  logic [1:0]      key_col;
  logic            is_digit, is_enter, is_abort, is_bksp;
  logic [3:0]      key_digit;
  logic            decode_next;
  logic            tmo_fire;
  logic [ValW-1:0] base_val;
  logic [CntW-1:0] base_cnt;

  assign col_low    = ~col_matriz;
  assign single_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

  // Scan / debounce control
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    db_d    = db_q;
    case (state_q)
      StScan: begin
        if (!enable) begin
          state_d = StDisabled;
        end else if (single_low) begin
          col_d   = col_matriz;
          db_d    = '0;
          state_d = StDebounce;
        end else begin
          row_d = row_q + 2'd1;
        end
      end
      StDebounce: begin
        if (col_matriz != col_q) begin
          db_d    = '0;
          state_d = StScan;
        end else if (db_q == DbLast) begin
          db_d    = '0;
          state_d = StDecode;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      StDecode: begin
        db_d    = '0;
        state_d = StWaitRelease;
      end
      StWaitRelease: begin
        if (col_matriz != 4'hF) begin
          db_d = '0;
        end else if (db_q == DbLast) begin
          db_d    = '0;
          state_d = StScan;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      StDisabled: begin
        if (enable) begin
          row_d   = 2'd0;
          state_d = StScan;
        end
      end
      default: state_d = StScan;
    endcase
  end

  assign decode_next = (state_q == StDebounce) && (state_d == StDecode);

  always_comb begin
    case (col_q)
      4'b0111: key_col = 2'd0;
      4'b1011: key_col = 2'd1;
      4'b1101: key_col = 2'd2;
      default: key_col = 2'd3;
    endcase
  end

  // Row 3 holds * 0 # D; column 3 of rows 0-2 holds the ignored A/B/C
  always_comb begin
    is_digit  = 1'b0;
    is_enter  = 1'b0;
    is_abort  = 1'b0;
    is_bksp   = 1'b0;
    key_digit = 4'd0;
    if (row_q == 2'd3) begin
      case (key_col)
        2'd0:    is_enter = 1'b1;
        2'd1:    is_digit = 1'b1;
        2'd2:    is_abort = 1'b1;
        default: is_bksp  = 1'b1;
      endcase
    end else if (key_col != 2'd3) begin
      is_digit  = 1'b1;
      key_digit = 4'(row_q) * 4'd3 + 4'(key_col) + 4'd1;
    end
  end

  // Buffer, timeout and frame generation
  always_comb begin
    // The cycle after a frame strobe the buffer restarts empty
    base_val = valid_q ? AllF : val_q;
    base_cnt = valid_q ? '0 : cnt_q;
    val_d    = base_val;
    cnt_d    = base_cnt;
    valid_d  = 1'b0;
    kind_d   = kind_q;
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;

    if (state_q == StDecode || valid_q) begin
      tmo_d = '0;
    end else if (cnt_q != '0 && state_q != StDisabled) begin
      if (tmo_q == TmoLast) begin
        // A key about to decode beats the timeout; hold until DECODE clears it
        if (!decode_next) begin
          tmo_fire = 1'b1;
          tmo_d    = '0;
        end
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (state_q == StDecode) begin
      if (is_digit) begin
        val_d = {base_val[ValW-5:0], key_digit};
        if (base_cnt != CntW'(DIGITS)) cnt_d = base_cnt + 1'b1;
      end else if (is_enter) begin
        valid_d = 1'b1;
        kind_d  = KindEnter;
      end else if (is_abort) begin
        val_d   = AllB;
        cnt_d   = '0;
        valid_d = 1'b1;
        kind_d  = KindAbort;
      end else if (is_bksp && base_cnt != '0) begin
        val_d = {4'hF, base_val[ValW-1:4]};
        cnt_d = base_cnt - 1'b1;
      end
    end else if (tmo_fire) begin
      val_d   = AllE;
      cnt_d   = '0;
      valid_d = 1'b1;
      kind_d  = KindTimeout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StScan;
      row_q   <= 2'd0;
      col_q   <= 4'hF;
      db_q    <= '0;
      tmo_q   <= '0;
      val_q   <= AllF;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= KindEnter;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      db_q    <= db_d;
      tmo_q   <= tmo_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
    end
  end

  assign lin_matriz   = (state_q == StDisabled) ? 4'hF : ~(4'b1000 >> row_q);
  assign digits_value = val_q;
  assign digit_count  = cnt_q;
  assign digits_valid = valid_q;
  assign frame_kind   = kind_q;

endmodule

// File: tb/tb_keypad_entry_collector.sv
module tb_keypad_entry_collector;
  localparam int unsigned DIGITS = 20;
  localparam int unsigned DB     = 100;
  localparam int unsigned TMO    = 5000;
  localparam int unsigned VW     = 4 * DIGITS;
  localparam int unsigned CW     = $clog2(DIGITS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [3:0]    col_matriz;
  logic [3:0]    lin_matriz;
  logic [VW-1:0] digits_value;
  logic          digits_valid;
  logic [CW-1:0] digit_count;
  logic [1:0]    frame_kind;

  keypad_entry_collector #(
    .DIGITS(DIGITS),
    .DB_CYCLES(DB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .col_matriz(col_matriz),
    .lin_matriz(lin_matriz),
    .digits_value(digits_value),
    .digits_valid(digits_valid),
    .digit_count(digit_count),
    .frame_kind(frame_kind)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: the held key pulls its columns low only while its row is driven
  logic       pressed = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [3:0] key_mask = 4'hF;
  always_comb begin
    col_matriz = 4'hF;
    if (pressed && lin_matriz == ~(4'b1000 >> key_r)) col_matriz = key_mask;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_v(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_i(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference model: list of digits, newest first
  int            mq[$];
  logic [VW-1:0] ev[$];
  int            ec[$];   // -1: count not compared
  int            ek[$];

  // Frames observed on the DUT
  logic [VW-1:0] gv[$];
  int            gc[$];
  int            gk[$];
  int            gt[$];

  function automatic logic [VW-1:0] build_val();
    logic [VW-1:0] v;
    v = '1;
    for (int i = 0; i < mq.size(); i++) v[4*i +: 4] = 4'(mq[i]);
    return v;
  endfunction

  // sym: 0-9 digits, 10 '*', 11 '#', 12 D, 13 A, 14 B, 15 C
  task automatic model_apply(input int sym);
    if (sym <= 9) begin
      mq.push_front(sym);
      if (mq.size() > DIGITS) void'(mq.pop_back());
    end else if (sym == 10) begin
      ev.push_back(build_val()); ec.push_back(mq.size()); ek.push_back(0);
      mq.delete();
    end else if (sym == 11) begin
      ev.push_back({DIGITS{4'hB}}); ec.push_back(0); ek.push_back(1);
      mq.delete();
    end else if (sym == 12) begin
      if (mq.size() > 0) void'(mq.pop_front());
    end
  endtask

  task automatic sym_pos(input int sym, output logic [1:0] r, output logic [1:0] c);
    r = 2'd3; c = 2'd3;
    if (sym >= 1 && sym <= 9) begin
      r = 2'((sym - 1) / 3); c = 2'((sym - 1) % 3);
    end else begin
      case (sym)
        0:  begin r = 2'd3; c = 2'd1; end
        10: begin r = 2'd3; c = 2'd0; end
        11: begin r = 2'd3; c = 2'd2; end
        13: begin r = 2'd0; c = 2'd3; end
        14: begin r = 2'd1; c = 2'd3; end
        15: begin r = 2'd2; c = 2'd3; end
        default: begin r = 2'd3; c = 2'd3; end
      endcase
    end
  endtask

  task automatic press(input int sym, input int hold, input int rel);
    logic [1:0] r, c;
    sym_pos(sym, r, c);
    @(negedge clk);
    key_r = r; key_mask = ~(4'b1000 >> c); pressed = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic compare_frames(input string tag);
    check_i({tag, "_nframes"}, gv.size(), ev.size());
    while (gv.size() > 0 && ev.size() > 0) begin
      int xc, gcv;
      check_v({tag, "_fval"}, gv.pop_front(), ev.pop_front());
      check_i({tag, "_fkind"}, gk.pop_front(), ek.pop_front());
      xc = ec.pop_front();
      gcv = gc.pop_front();
      if (xc >= 0) check_i({tag, "_fcount"}, gcv, xc);
    end
    gv.delete(); gc.delete(); gk.delete(); gt.delete();
    ev.delete(); ec.delete(); ek.delete();
  endtask

  task automatic verify(input string tag);
    compare_frames(tag);
    check_i({tag, "_count"}, int'(digit_count), mq.size());
    check_v({tag, "_value"}, digits_value, build_val());
  endtask

  task automatic key(input string tag, input int sym);
    press(sym, 150, 150);
    model_apply(sym);
    verify(tag);
  endtask

  // Frame monitor: records strobes and checks the post-frame clear cycle
  logic prev_valid = 1'b0;
  int   prev_count = 0;
  int   change_cyc = 0;
  always @(negedge clk) begin
    if (prev_valid) begin
      check_i("no_back_to_back", int'(digits_valid), 0);
      check_v("clear_value", digits_value, {DIGITS{4'hF}});
      check_i("clear_count", int'(digit_count), 0);
    end
    if (digits_valid) begin
      gv.push_back(digits_value);
      gc.push_back(int'(digit_count));
      gk.push_back(int'(frame_kind));
      gt.push_back(cyc);
    end
    if (int'(digit_count) != prev_count) change_cyc = cyc;
    prev_count = int'(digit_count);
    prev_valid = digits_valid;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r, c;
    int t7;
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_i("rst_lin", int'(lin_matriz), 4'b0111);
    check_v("rst_value", digits_value, {DIGITS{4'hF}});
    check_i("rst_count", int'(digit_count), 0);
    check_i("rst_valid", int'(digits_valid), 0);
    check_i("rst_kind", int'(frame_kind), 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] exp_lin;
      @(negedge clk);
      exp_lin = ~(4'b1000 >> (i % 4));
      check_i("scan_rotate", int'(lin_matriz), int'(exp_lin));
    end

    // 1 2 3 enter
    key("k1", 1); key("k2", 2); key("k3", 3);
    key("enter123", 10);

    // 22 digits overflow
    for (int i = 0; i < 22; i++) begin
      press(i % 10, 150, 150);
      model_apply(i % 10);
    end
    press(10, 150, 150);
    model_apply(10);
    if (gv.size() > 0) begin
      check_i("ovf_nib0", int'(gv[0][3:0]), 1);
      check_i("ovf_count", gc[0], 20);
    end
    verify("ovf");

    // backspace
    key("k4", 4); key("k5", 5); key("bksp", 12); key("k6", 6);
    key("enter46", 10);
    key("bksp_empty", 12);

    // bouncing contact on key 8, then a clean hold
    sym_pos(8, r, c);
    @(negedge clk);
    key_r = r; key_mask = ~(4'b1000 >> c);
    for (int i = 0; i < 17; i++) begin
      pressed = (i % 2 == 0);
      repeat (30) @(negedge clk);
    end
    pressed = 1'b1;
    repeat (110) @(negedge clk);
    pressed = 1'b0;
    repeat (150) @(negedge clk);
    model_apply(8);
    verify("bounce");

    // two columns low in one row
    key_r = 2'd1; key_mask = 4'b0101; pressed = 1'b1;
    repeat (150) @(negedge clk);
    pressed = 1'b0;
    repeat (150) @(negedge clk);
    verify("two_cols");

    // abort with digits held
    key("a1", 1); key("a2", 2);
    key("abort", 11);

    // disable freezes buffer and timeout
    key("d5", 5);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_i("dis_lin", int'(lin_matriz), 4'hF);
    press(9, 150, 150);
    repeat (TMO) @(negedge clk);
    verify("disabled");
    enable = 1'b1;
    @(negedge clk);
    check_i("reen_lin", int'(lin_matriz), 4'b0111);
    key("dis_enter", 10);

    // timeout
    key("t7", 7);
    t7 = change_cyc;
    for (int i = 0; i < TMO + 500 && gv.size() == 0; i++) @(negedge clk);
    if (gt.size() > 0) begin
      checks++;
      assert ((gt[0] - t7) >= int'(TMO) - 2 && (gt[0] - t7) <= int'(TMO) + 2) else begin
        errors++;
        $error("FAIL tmo_delay got %0d exp %0d", gt[0] - t7, TMO);
      end
    end
    ev.push_back({DIGITS{4'hE}}); ec.push_back(-1); ek.push_back(2);
    mq.delete();
    repeat (5) @(negedge clk);
    verify("timeout");
    repeat (TMO + 200) @(negedge clk);
    verify("no_empty_tmo");

    // randomized key sequence
    for (int n = 0; n < 30; n++) begin
      int sym;
      sym = (n == 29) ? 10 : int'($urandom_range(0, 15));
      press(sym, int'(DB) + 5 + int'($urandom_range(0, 40)),
            int'(DB) + 5 + int'($urandom_range(0, 40)));
      model_apply(sym);
      verify("rand");
    end

    // reset during debounce of an enter
    key("r1", 1); key("r2", 2); key("r3", 3);
    sym_pos(10, r, c);
    @(negedge clk);
    key_r = r; key_mask = ~(4'b1000 >> c); pressed = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check_i("mid_rst_lin", int'(lin_matriz), 4'b0111);
    check_v("mid_rst_value", digits_value, {DIGITS{4'hF}});
    check_i("mid_rst_count", int'(digit_count), 0);
    check_i("mid_rst_valid", int'(digits_valid), 0);
    check_i("mid_rst_kind", int'(frame_kind), 0);
    repeat (5) @(negedge clk);
    pressed = 1'b0;
    rst = 1'b0;
    mq.delete();
    repeat (300) @(negedge clk);
    verify("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_collector.md
# keypad_entry_collector

Parametrised successor to the team's 4×4 matrix keypad decoder. It scans the keypad rows, debounces each press and its release, and decodes the key. Digits are accumulated into a DIGITS-deep nibble buffer with backspace support. Complete frames, or abort/timeout codes, are emitted to the downstream password/compare logic with a one-cycle valid pulse.

## Interface
- DIGITS, 20: buffer depth in 4-bit digits (≥2).
- DB_CYCLES, 100: consecutive stable cycles required for press and for release (≥1).
- TIMEOUT_CYCLES, 5000: idle cycles after the last accepted key before a timeout frame is emitted (≥2).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  scanning allowed when high.
- col_matriz  in  4  column sense, active-low; bit 3-c low means column c is pressed.
- lin_matriz  out  4  row drive, active-low one-hot; bit 3-r low drives row r.
- digits_value  out  4*DIGITS  digit buffer; nibble 0 is the newest digit, unused nibbles are 0xF.
- digits_valid  out  1  one-cycle frame strobe.
- digit_count  out  $clog2(DIGITS+1)  number of digits held.
- frame_kind  out  2  qualifier, meaningful while digits_valid is high: 0 = enter, 1 = abort, 2 = timeout.

## Operation
- Key legend (row, col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
- Key actions:
  - Digits 0–9 are shifted into nibble 0; older digits move up and nibble DIGITS-1 is discarded.
  - digit_count saturates at DIGITS.
  - `*` = enter, `#` = abort, `D` = backspace, and A/B/C are ignored. Ignored keys still need a debounced press and release.
- States and transitions:
  - SCAN:
    - lin_matriz rotates every cycle in the order 0111 → 1011 → 1101 → 1110 → 0111.
    - If exactly one col bit is low, latch row and col and go to DEBOUNCE. The row is held from then on.
    - A pattern with several col bits low is ignored, and scanning continues.
    - If enable is low, go to DISABLED.
  - DEBOUNCE: counts cycles while col_matriz equals the latched pattern.
    - Any change of the pattern returns to SCAN.
    - When the count reaches DB_CYCLES, go to DECODE.
  - DECODE (1 cycle): apply the key action, then go to WAIT_RELEASE.
  - WAIT_RELEASE: requires col_matriz = 1111 for DB_CYCLES consecutive cycles.
    - Any low bit restarts the count.
    - When the count completes, go to SCAN.
  - DISABLED:
    - lin_matriz = 1111.
    - The buffer and the timeout counter are frozen.
    - Returns to SCAN on the first cycle enable is high. Row scanning restarts at 0111.
- Enter:
  - digits_valid pulses with frame_kind = 0.
  - digits_value and digit_count show the buffer contents during the pulse.
  - The buffer is cleared the next cycle: all nibbles 0xF, count 0.
  - Enter with an empty buffer still emits a frame, with value all 0xF and count 0.
- Abort: the same cycle that digits_valid pulses, every nibble reads 0xB, count 0 and frame_kind = 1. The buffer is cleared the next cycle.
- Backspace:
  - Nibbles shift down by one, with nibble DIGITS-1 filled with 0xF.
  - digit_count decrements.
  - With an empty buffer, backspace does nothing.
- Timeout:
  - The counter runs only while digit_count > 0 and the state is not DISABLED.
  - It is reset by every DECODE.
  - When it reaches TIMEOUT_CYCLES, a frame is emitted: every nibble reads 0xE, frame_kind = 2. The buffer is cleared the next cycle.
  - If a timeout and a DECODE coincide, the DECODE wins and the timeout counter is reset.

## Timing
- Reset values:
  - lin_matriz = 0111 and state SCAN.
  - digits_value all 0xF, digit_count 0, digits_valid 0, frame_kind 0.
  - All counters 0.
- Press latency: col is first seen low in cycle t (SCAN). DECODE occurs in cycle t+DB_CYCLES+1. The registered outputs change in cycle t+DB_CYCLES+2.
- digits_valid is high for exactly one cycle per frame. It is never high on two consecutive cycles.
- Clearing the buffer after a frame happens one cycle after the pulse. During that cycle the frame values remain visible.
- Mid-operation reset returns every output to its reset value immediately. Nothing partially collected is emitted.
- Deasserting enable during DEBOUNCE or WAIT_RELEASE: the in-progress key completes. DISABLED is entered from the next SCAN.

## Test plan
- Press 1, 2, 3, each held for 150 cycles then released for 150 cycles, then press `*` (DB_CYCLES = 100) -> one valid pulse, frame_kind 0, nibbles [2:0] = 1,2,3 (nibble 0 = 3), count 3; next cycle all 0xF, count 0.
- Enter 22 digits 0..9,0,1 with DIGITS = 20, then `*` -> count 20; the oldest two digits are discarded; nibble 0 = 1.
- Press 4, 5, D, 6, `*` -> frame reads 6 in nibble 0, 4 in nibble 1, count 2. D on an empty buffer -> no change and no pulse.
- Press 7, then stay idle with TIMEOUT_CYCLES = 5000 -> after 5000 cycles one pulse with frame_kind 2, all 0xE; a pulse with the buffer empty never occurs.
- Column bounce every 30 cycles for 500 cycles, then stable for 100 cycles -> exactly one digit accepted. Two columns low at once -> ignored.
- Press `#` with 3 digits held -> pulse with frame_kind 1, all 0xB. Assert rst mid-DEBOUNCE -> all outputs at reset values and no pulse.
